// File: rtl/lp_esc_clock_data_recovery.sv
// Oversampled LP escape-mode clock and data recovery for NUM_TRIOS independent C-PHY trios.
// Each trio synchronises A/C, deglitches A^C, decodes spaced-one-hot bits and assembles bytes.
module lp_esc_clock_data_recovery #(
    parameter int NUM_TRIOS      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int GLITCH_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NUM_TRIOS-1:0]   En,
    input  logic [NUM_TRIOS-1:0]   A,
    input  logic [NUM_TRIOS-1:0]   C,
    output logic [NUM_TRIOS-1:0]   RxClkEsc,
    output logic [NUM_TRIOS-1:0]   BitValid,
    output logic [NUM_TRIOS-1:0]   BitData,
    output logic [NUM_TRIOS-1:0]   ByteValid,
    output logic [8*NUM_TRIOS-1:0] ByteData,
    output logic [NUM_TRIOS-1:0]   ErrCollision,
    output logic [NUM_TRIOS-1:0]   ErrTimeout
);

    localparam int RunW = $clog2(GLITCH_CYCLES + 1);
    localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RunW-1:0] RunLast = RunW'(GLITCH_CYCLES - 1);
    localparam logic [RunW-1:0] CollSat = RunW'(GLITCH_CYCLES);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {FiltLow, FiltHigh} filtState_t;

    for (genvar t = 0; t < NUM_TRIOS; t++) begin : gTrio
        logic [SYNC_STAGES-1:0] aSync, cSync;
        logic                   aLvl, cLvl, x;
        filtState_t             state, stateNext;
        logic [RunW-1:0]        runCnt, runCntNext, collCnt, collCntNext;
        logic                   rise, collision;
        logic [2:0]             bitCnt;
        logic [7:0]             shiftReg, byteReg;
        logic [ToW-1:0]         toCnt;
        logic                   bitValidQ, bitDataQ, byteValidQ, errCollQ, errToQ;

        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                aSync <= '0;
                cSync <= '0;
            end else begin
                aSync <= {aSync[SYNC_STAGES-2:0], A[t]};
                cSync <= {cSync[SYNC_STAGES-2:0], C[t]};
            end
        end

        assign aLvl = aSync[SYNC_STAGES-1];
        assign cLvl = cSync[SYNC_STAGES-1];
        assign x    = aLvl ^ cLvl;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                state   <= FiltLow;
                runCnt  <= '0;
                collCnt <= '0;
            end else begin
                state   <= stateNext;
                runCnt  <= runCntNext;
                collCnt <= collCntNext;
            end
        end

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            stateNext   = state;
            runCntNext  = '0;
            collCntNext = '0;
            rise        = 1'b0;
            collision   = 1'b0;
            if (!En[t]) begin
                stateNext = FiltLow;
            end else begin
                unique case (state)
                    FiltLow: begin
                        if (x) begin
                            if (runCnt == RunLast) begin
                                stateNext = FiltHigh;
                                rise      = 1'b1;
                            end else begin
                                runCntNext = runCnt + RunW'(1);
                            end
                        end
                        // Collision counter saturates so a long A=C=1 hold flags only once.
                        if (aLvl && cLvl) begin
                            collCntNext = (collCnt == CollSat) ? CollSat : collCnt + RunW'(1);
                            collision   = (collCnt == RunLast);
                        end
                    end
                    FiltHigh: begin
                        if (!x) begin
                            if (runCnt == RunLast) stateNext = FiltLow;
                            else runCntNext = runCnt + RunW'(1);
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                bitCnt     <= '0;
                shiftReg   <= '0;
                byteReg    <= '0;
                toCnt      <= '0;
                bitValidQ  <= 1'b0;
                bitDataQ   <= 1'b0;
                byteValidQ <= 1'b0;
                errCollQ   <= 1'b0;
                errToQ     <= 1'b0;
            end else if (!En[t]) begin
                bitCnt     <= '0;
                shiftReg   <= '0;
                toCnt      <= '0;
                bitValidQ  <= 1'b0;
                byteValidQ <= 1'b0;
                errCollQ   <= 1'b0;
                errToQ     <= 1'b0;
            end else begin
                bitValidQ  <= rise;
                byteValidQ <= 1'b0;
                errCollQ   <= collision;
                errToQ     <= 1'b0;
                if (collision) begin
                    bitCnt   <= '0;
                    shiftReg <= '0;
                    toCnt    <= '0;
                end else if (rise) begin
                    bitDataQ <= aLvl;
                    toCnt    <= '0;
                    if (bitCnt == 3'd7) begin
                        byteValidQ <= 1'b1;
                        byteReg    <= {aLvl, shiftReg[7:1]};
                        shiftReg   <= '0;
                        bitCnt     <= '0;
                    end else begin
                        shiftReg <= {aLvl, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                    end
                end else if (bitCnt != 3'd0) begin
                    if (toCnt == ToLast) begin
                        errToQ   <= 1'b1;
                        toCnt    <= '0;
                        bitCnt   <= '0;
                        shiftReg <= '0;
                    end else begin
                        toCnt <= toCnt + ToW'(1);
                    end
                end else begin
                    toCnt <= '0;
                end
            end
        end

        assign RxClkEsc[t]       = (state == FiltHigh);
        assign BitValid[t]       = bitValidQ;
        assign BitData[t]        = bitDataQ;
        assign ByteValid[t]      = byteValidQ;
        assign ByteData[8*t +: 8] = byteReg;
        assign ErrCollision[t]   = errCollQ;
        assign ErrTimeout[t]     = errToQ;
    end

endmodule

// File: tb/tb_lp_esc_clock_data_recovery.sv
// Scoreboard bench: drivers push expected events from a symbol-level model; a negedge monitor pops and compares.
module tb_lp_esc_clock_data_recovery;

    localparam int NT  = 2;
    localparam int SS  = 2;
    localparam int GC  = 3;
    localparam int TC  = 255;
    localparam int LAT = SS + GC;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic [NT-1:0]   En, A, C;
    logic [NT-1:0]   RxClkEsc, BitValid, BitData, ByteValid, ErrCollision, ErrTimeout;
    logic [8*NT-1:0] ByteData;

    lp_esc_clock_data_recovery #(
        .NUM_TRIOS(NT), .SYNC_STAGES(SS), .GLITCH_CYCLES(GC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .A(A), .C(C),
        .RxClkEsc(RxClkEsc), .BitValid(BitValid), .BitData(BitData),
        .ByteValid(ByteValid), .ByteData(ByteData),
        .ErrCollision(ErrCollision), .ErrTimeout(ErrTimeout)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef enum int {EvRise, EvBit, EvByte, EvColl, EvTo} evKind_t;
    typedef struct {
        evKind_t    kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    ev_t evQ [NT][$];
    int  checks = 0;
    int  errors = 0;

    // Symbol-level model: partial byte as accumulated bits, plus last completed byte.
    logic [7:0] partByte [NT];
    int         partLen  [NT];
    int         lastBit  [NT];
    logic [7:0] lastByte [NT];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic pushEv(input int t, input evKind_t k, input int c, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        evQ[t].push_back(e);
    endtask

    task automatic clearPart(input int t);
        partLen[t]  = 0;
        partByte[t] = '0;
    endtask

    // Advance one clock; once no future bit can land in time, the pending timeout becomes certain.
    task automatic tick();
        @(posedge Clk);
        #1;
        for (int t = 0; t < NT; t++) begin
            if (partLen[t] != 0 && lastBit[t] + TC < cyc + LAT) begin
                pushEv(t, EvTo, lastBit[t] + TC, lastByte[t]);
                clearPart(t);
            end
        end
    endtask

    task automatic drivePulse(input int t, input logic a, input logic c, input int width, input int gap);
        A[t] = a;
        C[t] = c;
        repeat (width) tick();
        A[t] = 1'b0;
        C[t] = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic sendBit(input int t, input logic v, input int width, input int gap);
        int e;
        e = cyc + LAT;
        pushEv(t, EvRise, e, 8'h00);
        pushEv(t, EvBit, e, {7'b0, v});
        partByte[t][partLen[t]] = v;
        partLen[t]++;
        lastBit[t] = e;
        if (partLen[t] == 8) begin
            pushEv(t, EvByte, e, partByte[t]);
            lastByte[t] = partByte[t];
            clearPart(t);
        end
        drivePulse(t, v, !v, width, gap);
    endtask

    task automatic sendByte(input int t, input logic [7:0] b, input int width, input int gap);
        for (int i = 0; i < 8; i++) sendBit(t, b[i], width, gap);
    endtask

    task automatic collide(input int t, input int width, input int gap);
        pushEv(t, EvColl, cyc + LAT, 8'h00);
        clearPart(t);
        drivePulse(t, 1'b1, 1'b1, width, gap);
    endtask

    task automatic enDrop(input int t, input int n);
        En[t] = 1'b0;
        clearPart(t);
        repeat (n) tick();
        En[t] = 1'b1;
    endtask

    task automatic randomRun(input int t, input int nSym);
        int r;
        for (int s = 0; s < nSym; s++) begin
            r = $urandom_range(0, 19);
            if (r < 12)
                sendBit(t, 1'($urandom_range(0, 1)), $urandom_range(GC, GC + 8), $urandom_range(GC + 1, GC + 6));
            else if (r < 15)
                drivePulse(t, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, GC - 1), $urandom_range(GC + 1, GC + 6));
            else if (r < 17)
                collide(t, $urandom_range(GC, GC + 3), $urandom_range(GC + 1, GC + 6));
            else if (r < 19)
                repeat ($urandom_range(1, 20)) tick();
            else
                repeat ($urandom_range(TC + 5, TC + 45)) tick();
        end
    endtask

    task automatic expectEv(input int t, input evKind_t k, input logic [7:0] d);
        ev_t     e;
        evKind_t ek;
        if (evQ[t].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL trio%0d unexpected %s at cyc %0d data %0h", t, k.name(), cyc, d);
        end else begin
            e  = evQ[t].pop_front();
            ek = e.kind;
            check($sformatf("trio%0d_%s", t, ek.name()),
                  64'({8'(k), 24'(cyc), d}), 64'({8'(e.kind), 24'(e.cyc), e.data}));
        end
    endtask

    logic [NT-1:0] prevRx = '0;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            prevRx <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                while (evQ[t].size() > 0 && evQ[t][0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL trio%0d missing event kind %0d due cyc %0d (now %0d)",
                             t, int'(evQ[t][0].kind), evQ[t][0].cyc, cyc);
                    void'(evQ[t].pop_front());
                end
                if (RxClkEsc[t] && !prevRx[t]) expectEv(t, EvRise, 8'h00);
                if (BitValid[t])     expectEv(t, EvBit, {7'b0, BitData[t]});
                if (ByteValid[t])    expectEv(t, EvByte, ByteData[8*t +: 8]);
                if (ErrCollision[t]) expectEv(t, EvColl, 8'h00);
                if (ErrTimeout[t])   expectEv(t, EvTo, ByteData[8*t +: 8]);
            end
            prevRx <= RxClkEsc;
        end
    end

    initial begin
        for (int t = 0; t < NT; t++) begin
            clearPart(t);
            lastBit[t]  = 0;
            lastByte[t] = '0;
        end
        Rst_n = 1'b0;
        En    = '1;
        A     = '0;
        C     = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", 64'({RxClkEsc, BitValid, BitData, ByteValid, ErrCollision, ErrTimeout, ByteData}), 64'd0);
        Rst_n = 1'b1;
        repeat (10) tick();
        check("idle_outputs", 64'({RxClkEsc, BitValid, BitData, ByteValid, ErrCollision, ErrTimeout, ByteData}), 64'd0);

        // Byte 0xA5 with wide pulses, then a sub-threshold glitch and a minimum-width pulse.
        sendByte(0, 8'hA5, 10, 6);
        check("byte_a5", 64'(ByteData[7:0]), 64'hA5);
        drivePulse(0, 1'b1, 1'b0, GC - 1, GC + 3);
        sendBit(0, 1'b1, GC, GC + 3);
        repeat (TC + 20) tick();

        // Three bits abandoned by timeout, then a clean byte.
        sendBit(0, 1'b0, 5, 5);
        sendBit(0, 1'b1, 5, 5);
        sendBit(0, 1'b1, 5, 5);
        repeat (TC + 20) tick();
        sendByte(0, 8'h5A, 5, 5);

        // Collision mid-byte discards the partial byte.
        sendBit(0, 1'b1, 5, 5);
        sendBit(0, 1'b0, 5, 5);
        collide(0, 4, 6);
        sendByte(0, 8'h96, 4, 4);
        check("byte_96", 64'(ByteData[7:0]), 64'h96);

        // Two trios in parallel; trio 1 loses its partial byte to an enable drop.
        fork
            sendByte(0, 8'h3C, 6, 5);
            begin
                sendBit(1, 1'b1, 5, 5);
                sendBit(1, 1'b1, 5, 5);
                sendBit(1, 1'b0, 5, 5);
                enDrop(1, 8);
                sendByte(1, 8'hC3, 5, 5);
            end
        join
        repeat (10) tick();
        check("dual_bytes", 64'(ByteData), 64'hC33C);

        fork
            randomRun(0, 60);
            randomRun(1, 60);
        join
        repeat (TC + 20) tick();

        // Reset asserted mid-byte returns everything to the reset state.
        sendBit(0, 1'b1, 5, 5);
        sendBit(0, 1'b0, 5, 5);
        Rst_n = 1'b0;
        for (int t = 0; t < NT; t++) begin
            clearPart(t);
            lastByte[t] = '0;
        end
        repeat (3) tick();
        check("midbyte_reset", 64'({RxClkEsc, BitValid, BitData, ByteValid, ErrCollision, ErrTimeout, ByteData}), 64'd0);
        Rst_n = 1'b1;
        repeat (2) tick();
        sendByte(0, 8'h69, 5, 5);
        repeat (20) tick();
        check("after_reset_byte", 64'(ByteData[7:0]), 64'h69);

        check("queue0_drained", 64'(evQ[0].size()), 64'd0);
        check("queue1_drained", 64'(evQ[1].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
